// File: rtl/song_pkg.sv
// Shared widths, ROM word layout and FSM encoding for the chord song reader.
// Pure declarations; no latency, no flow control.
// Imported by chord_song_reader and rest_timer.
package song_pkg;

    localparam int SONG_W  = 2;
    localparam int INDEX_W = 5;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int ADDR_W  = SONG_W + INDEX_W;
    localparam int WORD_W  = 16;

    localparam int WAIT_BIT = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;

    // Bits [NOTE_MSB:DUR_LSB] all zero with is_wait clear terminates a song.
    localparam logic [NOTE_MSB-DUR_LSB:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_REST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rest_timer.sv
// Beat-counted rest down-counter with load, clear and terminal-count pulse.
// Latency: tc is combinational on the beat that moves the count from 1 to 0.
// Backpressure: none; counts only while beat_en is high, holds otherwise.
module rest_timer
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             beat_en,
    output logic             tc
);

    logic [DUR_W-1:0] rest_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rest_cnt <= '0;
        end else if (load) begin
            rest_cnt <= load_val;
        end else if (beat_en && rest_cnt != '0) begin
            rest_cnt <= rest_cnt - DUR_W'(1);
        end
    end

    assign tc = beat_en && (rest_cnt == DUR_W'(1));

endmodule

// File: rtl/chord_song_reader.sv
// Walks one song ROM entry by entry, issuing notes, beat-counted rests and end-of-song.
// Latency: new_song at t -> FETCH t+1 -> DECODE t+2 -> earliest load_new_note at t+3.
// Backpressure: ISSUE stalls until voice_free; play_enable=0 freezes all progress.
module chord_song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic              new_song,
    input  logic [SONG_W-1:0] song,
    input  logic              beat,
    input  logic              voice_free,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [NOTE_W-1:0] note_to_load,
    output logic [DUR_W-1:0]  duration,
    output logic              load_new_note,
    output logic              activate,
    output logic              song_done
);

    state_t                       state, next_state;
    logic [INDEX_W-1:0]           index;
    logic [SONG_W-1:0]            song_reg;
    logic [NOTE_W+DUR_W-1:0]      word_reg;
    logic                         done_q;

    logic                         idx_adv;
    logic                         word_load;
    logic                         rest_load;
    logic                         load_pulse;
    logic                         rest_tc;
    logic                         last_idx;
    logic                         rom_is_wait;
    logic [DUR_W-1:0]             rom_dur;
    logic                         unused_rom_bits;

    assign rom_is_wait     = rom_data[WAIT_BIT];
    assign rom_dur         = rom_data[DUR_MSB:DUR_LSB];
    assign last_idx        = (index == '1);
    assign unused_rom_bits = ^rom_data[DUR_LSB-1:0];

    always_comb begin
        next_state = state;
        idx_adv    = 1'b0;
        word_load  = 1'b0;
        rest_load  = 1'b0;
        load_pulse = 1'b0;
        if (new_song) begin
            next_state = ST_FETCH;
        end else if (play_enable) begin
            case (state)
                ST_FETCH: next_state = ST_DECODE;
                ST_DECODE: begin
                    word_load = 1'b1;
                    if (!rom_is_wait && rom_data[NOTE_MSB:DUR_LSB] == END_MARKER) begin
                        next_state = ST_DONE;
                    end else if (rom_is_wait && rom_dur == '0) begin
                        idx_adv    = 1'b1;
                        next_state = last_idx ? ST_DONE : ST_FETCH;
                    end else if (rom_is_wait) begin
                        rest_load  = 1'b1;
                        next_state = ST_REST;
                    end else begin
                        next_state = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (voice_free) begin
                        load_pulse = 1'b1;
                        idx_adv    = 1'b1;
                        next_state = last_idx ? ST_DONE : ST_FETCH;
                    end
                end
                ST_REST: begin
                    if (rest_tc) begin
                        idx_adv    = 1'b1;
                        next_state = last_idx ? ST_DONE : ST_FETCH;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            index    <= '0;
            song_reg <= '0;
            word_reg <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (next_state == ST_DONE) && (state != ST_DONE);
            if (new_song) begin
                song_reg <= song;
                index    <= '0;
            end else if (idx_adv && !last_idx) begin
                index <= index + INDEX_W'(1);
            end
            if (word_load) begin
                word_reg <= rom_data[NOTE_MSB:DUR_LSB];
            end
        end
    end

    // A restart discards any rest in progress; no beat may count in that cycle.
    rest_timer u_rest_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (new_song),
        .load     (rest_load),
        .load_val (rom_dur),
        .beat_en  (beat && play_enable && !new_song && state == ST_REST),
        .tc       (rest_tc)
    );

    assign rom_addr      = {song_reg, index};
    assign load_new_note = load_pulse;
    assign note_to_load  = load_pulse ? word_reg[NOTE_W+DUR_W-1:DUR_W] : '0;
    assign duration      = load_pulse ? word_reg[DUR_W-1:0] : '0;
    assign activate      = play_enable && (state != ST_IDLE);
    assign song_done     = done_q && play_enable;

endmodule
